// File: rtl/aww_types_pkg.sv
// Shared types for the hazard control slice: the controller state
// encoding and the register-index type used by hazard comparisons.
package aww_types_pkg;

  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } hazard_state_t;

  typedef logic [REG_W_DEF-1:0] regbits_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating performance counters for the hazard controller: memory/fetch
// stall cycles, IF/ID flush cycles and load-use bubbles. Counting freezes
// once the processor is halted. Only built when HAZARD_PERF_EN is defined.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             halted,
  input  logic             stall_ev,
  input  logic             flush_ev,
  input  logic             bubble_ev,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Each counter steps on its event, sticks at all-ones, and holds in HALT.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!halted) begin
      if (stall_ev && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_ev && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_ONE;
      if (bubble_ev && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: produces the PC/pipeline-register enables,
// IF/ID flush and ID/EX bubble select from load-use, branch, jump, cache
// miss and halt conditions. A branch resolved while the pipeline is frozen
// is remembered in flush_pend and applied on the first advancing cycle.
// All control outputs are combinational from state and inputs.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush/bubble counters.
//
// Handshake note: the pipeline advances on a cycle exactly when
// advance=1, i.e. the pending memory access (data if EX/MEM holds a
// load/store, otherwise instruction fetch) reports a hit that cycle.
module hazard_ctrl
  import aww_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dmemREN,
  input  logic             exmem_dmemWEN,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             exmem_br_taken,
  input  logic             id_jump,
  input  logic             memwb_halt,
  output logic             pc_WEN,
  output logic             WEN,
  output logic             ifid_WEN,
  output logic             ifid_FLUSH,
  output logic             idex_BUBBLE,
  output logic             halted,
  output logic [1:0]       state_dbg
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  hazard_state_t state, state_n;
  logic          flush_pend, flush_pend_n;
  logic          dreq, advance, luse, brflush;

  // Hazard terms; nRST gates advance so every output is 0 during reset.
  always_comb begin
    dreq    = exmem_dmemREN | exmem_dmemWEN;
    advance = nRST & (state != HALT) & (dreq ? dhit : ihit);
    luse    = idex_memread & (idex_rd != '0) &
              ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));
    brflush = exmem_br_taken | flush_pend;
  end

  // State and pending-flush registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_n;
      flush_pend <= flush_pend_n;
    end
  end

  // Next state: halt overrides everything and drops any pending flush.
  always_comb begin
    state_n      = state;
    flush_pend_n = flush_pend;
    if (memwb_halt) begin
      state_n      = HALT;
      flush_pend_n = 1'b0;
    end else begin
      case (state)
        RUN:     if (dreq && !dhit) state_n = MEMWAIT;
        MEMWAIT: if (dhit) state_n = RUN;
        default: state_n = HALT;
      endcase
      if (state == HALT)
        flush_pend_n = 1'b0;
      else if (advance)
        flush_pend_n = 1'b0;
      else if (exmem_br_taken)
        flush_pend_n = 1'b1;
    end
  end

  // Output priority: branch flush, then load-use bubble, then jump flush.
  always_comb begin
    WEN         = advance;
    pc_WEN      = advance & ~luse;
    ifid_WEN    = 1'b0;
    ifid_FLUSH  = 1'b0;
    idex_BUBBLE = 1'b0;
    if (advance) begin
      if (brflush) begin
        ifid_FLUSH  = 1'b1;
        idex_BUBBLE = 1'b1;
        pc_WEN      = 1'b1;
      end else if (luse) begin
        idex_BUBBLE = 1'b1;
      end else if (id_jump) begin
        ifid_FLUSH  = 1'b1;
      end else begin
        ifid_WEN    = 1'b1;
      end
    end
  end

  assign halted    = (state == HALT);
  assign state_dbg = state;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .CLK        (CLK),
    .nRST       (nRST),
    .halted     (halted),
    .stall_ev   (~halted & ~advance),
    .flush_ev   (ifid_FLUSH),
    .bubble_ev  (advance & ~brflush & luse),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .bubble_cnt (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. A behavioural model tracks three
// facts (halted, a branch flush is owed, a data access is outstanding) and
// derives the expected control word from the rules each cycle.
// Control word layout: {pc_WEN, WEN, ifid_WEN, ifid_FLUSH, idex_BUBBLE,
// halted, state_dbg[1:0]}.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, exmem_dmemREN, exmem_dmemWEN, idex_memread;
  logic [REG_W-1:0] idex_rd, ifid_rs, ifid_rt;
  logic             exmem_br_taken, id_jump, memwb_halt;
  logic             pc_WEN, WEN, ifid_WEN, ifid_FLUSH, idex_BUBBLE, halted;
  logic [1:0]       state_dbg;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Model state
  bit m_halt, m_pend, m_wait;
  logic [7:0] exp_q[$];

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .dhit           (dhit),
    .exmem_dmemREN  (exmem_dmemREN),
    .exmem_dmemWEN  (exmem_dmemWEN),
    .idex_memread   (idex_memread),
    .idex_rd        (idex_rd),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .exmem_br_taken (exmem_br_taken),
    .id_jump        (id_jump),
    .memwb_halt     (memwb_halt),
    .pc_WEN         (pc_WEN),
    .WEN            (WEN),
    .ifid_WEN       (ifid_WEN),
    .ifid_FLUSH     (ifid_FLUSH),
    .idex_BUBBLE    (idex_BUBBLE),
    .halted         (halted),
    .state_dbg      (state_dbg)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  // Clock
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic bit model_advance();
    bit mem_access = exmem_dmemREN || exmem_dmemWEN;
    if (m_halt) return 1'b0;
    return mem_access ? dhit : ihit;
  endfunction

  function automatic logic [7:0] model_word();
    bit adv, hazard, flush_owed;
    logic [1:0] st;
    adv = model_advance();
    hazard = idex_memread && (idex_rd != 0) &&
             (idex_rd == ifid_rs || idex_rd == ifid_rt);
    flush_owed = exmem_br_taken || m_pend;
    st = m_halt ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
    if (!adv)            return {5'b00000, m_halt, st};
    else if (flush_owed) return {5'b11011, 1'b0, st};
    else if (hazard)     return {5'b01001, 1'b0, st};
    else if (id_jump)    return {5'b11010, 1'b0, st};
    else                 return {5'b11100, 1'b0, st};
  endfunction

  task automatic model_clock();
    bit adv = model_advance();
    if (memwb_halt) begin
      m_halt = 1; m_pend = 0; m_wait = 0;
    end else if (!m_halt) begin
      if (adv) m_pend = 0;
      else if (exmem_br_taken) m_pend = 1;
      if (m_wait) m_wait = !dhit;
      else m_wait = (exmem_dmemREN || exmem_dmemWEN) && !dhit;
    end
  endtask

  function automatic logic [7:0] dut_word();
    return {pc_WEN, WEN, ifid_WEN, ifid_FLUSH, idex_BUBBLE, halted, state_dbg};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ihit = 1; dhit = 0; exmem_dmemREN = 0; exmem_dmemWEN = 0;
    idex_memread = 0; idex_rd = 0; ifid_rs = 0; ifid_rt = 0;
    exmem_br_taken = 0; id_jump = 0; memwb_halt = 0;
  endtask

  // Samples at the falling edge, then clocks DUT and model together.
  task automatic step(output logic [7:0] got, output logic [7:0] exp);
    @(negedge CLK);
    exp_q.push_back(model_word());
    got = dut_word();
    exp = exp_q.pop_front();
    @(posedge CLK);
    model_clock();
    #1;
  endtask

  task automatic reset_on();
    ihit = 1;
    nRST = 0;
    m_halt = 0; m_pend = 0; m_wait = 0;
    #2;
  endtask

  task automatic reset_off();
    drive_idle();
    @(negedge CLK);
    #1 nRST = 1;
    @(posedge CLK);
    model_clock();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] g, e;
    drive_idle();
    nRST = 1;
    #1;
    reset_on();
    checks++;
    if (dut_word() !== 8'h00) begin
      errors++; $display("FAIL reset_async: got=%b want=%b", dut_word(), 8'h00);
    end
    @(posedge CLK); #1;
    checks++;
    if (dut_word() !== 8'h00) begin
      errors++; $display("FAIL reset_held: got=%b want=%b", dut_word(), 8'h00);
    end
    reset_off();
    step(g, e);
    checks++;
    if (g !== 8'b11100000) begin
      errors++; $display("FAIL reset_run: got=%b want=%b", g, 8'b11100000);
    end
  endtask

  task automatic test_load_use();
    logic [7:0] g, e;
    drive_idle();
    idex_memread = 1; idex_rd = 8; ifid_rs = 8; ifid_rt = 3;
    step(g, e);
    checks++;
    if (g !== 8'b01001000) begin
      errors++; $display("FAIL load_use_bubble: got=%b want=%b", g, 8'b01001000);
    end
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL load_use_model: got=%b want=%b", g, e);
    end
    idex_memread = 0; idex_rd = 0;
    step(g, e);
    checks++;
    if (g !== 8'b11100000) begin
      errors++; $display("FAIL load_use_resume: got=%b want=%b", g, 8'b11100000);
    end
  endtask

  task automatic test_rd_zero();
    logic [7:0] g, e;
    drive_idle();
    idex_memread = 1; idex_rd = 0; ifid_rt = 0; ifid_rs = 5;
    step(g, e);
    checks++;
    if (g !== 8'b11100000) begin
      errors++; $display("FAIL rd_zero: got=%b want=%b", g, 8'b11100000);
    end
  endtask

  task automatic test_branch_dmiss();
    logic [7:0] g, e;
    logic [7:0] want[5];
    want = '{8'b00000000, 8'b00000001, 8'b00000001, 8'b11011001, 8'b11100000};
    drive_idle();
    for (int i = 0; i < 5; i++) begin
      exmem_dmemREN  = (i < 4);
      exmem_br_taken = (i == 0);
      dhit           = (i == 3);
      step(g, e);
      checks++;
      if (g !== want[i]) begin
        errors++; $display("FAIL branch_dmiss[%0d]: got=%b want=%b", i, g, want[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] g, e;
    drive_idle();
    exmem_br_taken = 1; id_jump = 1;
    idex_memread = 1; idex_rd = 8; ifid_rs = 8;
    step(g, e);
    checks++;
    if (g !== 8'b11011000) begin
      errors++; $display("FAIL priority: got=%b want=%b", g, 8'b11011000);
    end
    drive_idle();
    id_jump = 1;
    step(g, e);
    checks++;
    if (g !== 8'b11010000) begin
      errors++; $display("FAIL jump_flush: got=%b want=%b", g, 8'b11010000);
    end
  endtask

  task automatic test_random();
    logic [7:0] g, e;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      ihit           = ($urandom_range(0, 3) != 0);
      dhit           = $urandom_range(0, 1) == 1;
      exmem_dmemREN  = (r == 1);
      exmem_dmemWEN  = (r == 2);
      idex_memread   = $urandom_range(0, 1) == 1;
      idex_rd        = REG_W'($urandom_range(0, 3));
      ifid_rs        = REG_W'($urandom_range(0, 3));
      ifid_rt        = REG_W'($urandom_range(0, 3));
      exmem_br_taken = ($urandom_range(0, 7) == 0);
      id_jump        = ($urandom_range(0, 5) == 0);
      memwb_halt     = 0;
      step(g, e);
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL random[%0d]: got=%b want=%b", i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [7:0] g, e;
    drive_idle();
    exmem_dmemREN = 1; exmem_br_taken = 1;
    step(g, e);
    exmem_br_taken = 0;
    step(g, e);
    checks++;
    if (g !== 8'b00000001) begin
      errors++; $display("FAIL stall_before_reset: got=%b want=%b", g, 8'b00000001);
    end
    reset_on();
    checks++;
    if (dut_word() !== 8'h00) begin
      errors++; $display("FAIL reset_mid_stall: got=%b want=%b", dut_word(), 8'h00);
    end
    reset_off();
    step(g, e);
    checks++;
    if (g !== 8'b11100000) begin
      errors++; $display("FAIL pend_cleared: got=%b want=%b", g, 8'b11100000);
    end
  endtask

  task automatic test_halt();
    logic [7:0] g, e;
    drive_idle();
    memwb_halt = 1; exmem_br_taken = 1;
    step(g, e);
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL halt_edge: got=%b want=%b", g, e);
    end
    for (int i = 0; i < 6; i++) begin
      drive_idle();
      dhit = 1;
      exmem_br_taken = $urandom_range(0, 1) == 1;
      step(g, e);
      checks++;
      if (g !== 8'b00000110) begin
        errors++; $display("FAIL halted[%0d]: got=%b want=%b", i, g, 8'b00000110);
      end
    end
    reset_on();
    checks++;
    if (dut_word() !== 8'h00) begin
      errors++; $display("FAIL halt_reset: got=%b want=%b", dut_word(), 8'h00);
    end
    reset_off();
    step(g, e);
    checks++;
    if (g !== 8'b11100000) begin
      errors++; $display("FAIL halt_exit: got=%b want=%b", g, 8'b11100000);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    logic [7:0] g, e;
    drive_idle();
    reset_on();
    reset_off();
    ihit = 0;
    for (int i = 0; i < 5; i++) step(g, e);
    drive_idle(); exmem_br_taken = 1; step(g, e);
    drive_idle(); step(g, e);
    drive_idle(); id_jump = 1; step(g, e);
    drive_idle(); idex_memread = 1; idex_rd = 4; ifid_rt = 4; step(g, e);
    drive_idle(); step(g, e);
    checks++;
    if (stall_cnt !== 32'd5) begin
      errors++; $display("FAIL perf_stall: got=%0d want=5", stall_cnt);
    end
    checks++;
    if (flush_cnt !== 32'd2) begin
      errors++; $display("FAIL perf_flush: got=%0d want=2", flush_cnt);
    end
    checks++;
    if (bubble_cnt !== 32'd1) begin
      errors++; $display("FAIL perf_bubble: got=%0d want=1", bubble_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_load_use();
    test_rd_zero();
    test_branch_dmiss();
    test_priority();
    test_random();
    test_reset_mid_stall();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
